// File: rtl/fifo_param.sv
// fifo_param: valid/ready FIFO of any depth with occupancy count, almost flags, flush and optional registered output.
module fifo_param #(
   parameter int SIZEDATA    = 32,
   parameter int DEPTHFIFO   = 8,
   parameter int ALMOSTFULL  = 6,
   parameter int ALMOSTEMPTY = 2,
   parameter int REGOUT      = 0,
   parameter int CNTW        = $clog2(DEPTHFIFO + 1)
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                flush_i,
   input  logic                valid_i,
   input  logic [SIZEDATA-1:0] data_i,
   output logic                ready_o,
   output logic                valid_o,
   output logic [SIZEDATA-1:0] data_o,
   input  logic                ready_i,
   output logic [CNTW-1:0]     count_o,
   output logic                almost_full_o,
   output logic                almost_empty_o
);
   localparam int PW = $clog2(DEPTHFIFO);
   localparam logic [PW-1:0] LAST = PW'(DEPTHFIFO - 1);
   logic [SIZEDATA-1:0] mem [DEPTHFIFO];
   logic [PW-1:0] wptr, rptr;
   logic [CNTW-1:0] count;
   logic push, pop, bypass, adv_r;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == LAST ? '0 : p + 1'b1;
   endfunction
   assign ready_o        = count != CNTW'(DEPTHFIFO);
   assign push           = valid_i && ready_o;
   assign pop            = valid_o && ready_i;
   assign count_o        = count;
   assign almost_full_o  = count >= CNTW'(ALMOSTFULL);
   assign almost_empty_o = count <= CNTW'(ALMOSTEMPTY);
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push && !bypass) wptr <= nxt(wptr);
         if (adv_r) rptr <= nxt(rptr);
         count <= count + CNTW'(push) - CNTW'(pop);
      end
   end
   always_ff @(posedge clk_i)
      if (push && !bypass && !flush_i) mem[wptr] <= data_i;
   generate
      if (REGOUT != 0) begin : g_reg
         logic [SIZEDATA-1:0] dreg;
         logic                vreg;
         // the output register holds the head; storage only sees entries behind it
         assign bypass  = push && (count == '0 || (pop && count == CNTW'(1)));
         assign adv_r   = pop && count > CNTW'(1);
         assign valid_o = vreg;
         assign data_o  = dreg;
         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               dreg <= '0;
               vreg <= 1'b0;
            end else if (flush_i) begin
               dreg <= '0;
               vreg <= 1'b0;
            end else if (bypass) begin
               dreg <= data_i;
               vreg <= 1'b1;
            end else if (adv_r) begin
               dreg <= mem[rptr];
            end else if (pop) begin
               dreg <= '0;
               vreg <= 1'b0;
            end
         end
      end else begin : g_comb
         assign bypass  = 1'b0;
         assign adv_r   = pop;
         assign valid_o = count != '0;
         assign data_o  = valid_o ? mem[rptr] : '0;
      end
   endgenerate
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO with valid/ready handshakes on both sides. It generalises the team's basic FIFO with:
- any depth ≥ 2, not only powers of two;
- an occupancy count;
- programmable almost-full and almost-empty flags;
- a synchronous flush;
- an optional registered output stage.

It sits between streaming producers and consumers wherever backpressure buffering and fill-level monitoring are needed.

## Interface
Parameters:
- SIZEDATA, 32, data width in bits (≥ 1)
- DEPTHFIFO, 8, capacity in entries (≥ 2, any integer)
- ALMOSTFULL, 6, almost_full_o asserts when count ≥ ALMOSTFULL (1..DEPTHFIFO)
- ALMOSTEMPTY, 2, almost_empty_o asserts when count ≤ ALMOSTEMPTY (0..DEPTHFIFO-1)
- REGOUT, 0, 0 = data_o driven combinationally from the storage head; 1 = data_o/valid_o driven directly from flops
- CNTW, $clog2(DEPTHFIFO+1), count width (derived; not overridden)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear, active high
- valid_i  in  1  producer has data
- data_i  in  SIZEDATA  write data
- ready_o  out  1  FIFO accepts data
- valid_o  out  1  FIFO has data
- data_o  out  SIZEDATA  head entry
- ready_i  in  1  consumer accepts data
- count_o  out  CNTW  entries held, 0..DEPTHFIFO
- almost_full_o  out  1  count_o ≥ ALMOSTFULL
- almost_empty_o  out  1  count_o ≤ ALMOSTEMPTY

## Operation
- Push = valid_i && ready_o at a rising edge. Pop = valid_o && ready_i at a rising edge.
- ready_o = (count < DEPTHFIFO). It depends only on registered state, with no combinational path from ready_i or valid_i.
- valid_o = (count ≠ 0). data_o is 0 whenever valid_o = 0 (both modes).
- Order is strictly first-in first-out. No entry is dropped or duplicated.
- Write and read pointers range 0..DEPTHFIFO-1 and wrap from DEPTHFIFO-1 to 0 on advance. There is no power-of-two aliasing.
- Count arithmetic:
  - push only: count+1
  - pop only: count-1
  - push and pop: unchanged
  - neither: unchanged
- Full with ready_i = 1: pop occurs, push is refused because ready_o = 0. The count becomes DEPTHFIFO-1 and ready_o rises the next cycle.
- Empty: no pop is possible. A push alone is accepted.
- REGOUT = 1: the head entry lives in an output register, and the capacity including that register is exactly DEPTHFIFO. The output register is loaded as follows:
  - on pop with storage non-empty: from the storage head;
  - on pop with storage empty and a simultaneous push: from data_i;
  - on push when the FIFO is empty: directly from data_i.
- flush_i = 1 at an edge:
  - pointers and count reset to 0, valid_o drops, output register clears;
  - flush has priority, so any push or pop in the same cycle is discarded;
  - storage contents are not cleared.
- Flags are decoded from the registered count and update on the same edge as count_o.

## Timing
- Reset (rstn_i low, asynchronous):
  - count_o = 0, valid_o = 0, data_o = 0, ready_o = 1;
  - almost_full_o = 0 (ALMOSTFULL ≥ 1), almost_empty_o = 1;
  - state is held until the first rising edge after rstn_i deasserts.
- Reset mid-operation drops all contents immediately, with no edge required.
- Write-to-read latency is 1 cycle in both modes. A push at edge N gives valid_o = 1 and the pushed data on data_o after edge N, when the FIFO was empty.
- Sustained push+pop every cycle gives 1 entry/cycle throughput at any fill level 1..DEPTHFIFO-1.
- count_o, ready_o, valid_o and the flags all reflect the same edge; none lags.
- In REGOUT = 1, data_o and valid_o are flop outputs with no logic after the register.

## Test plan
- Fill/drain, DEPTHFIFO=8, ready_i=0: push 0x01..0x08 → ready_o=0 after the 8th push and count_o=8. Assert ready_i → data_o reads 0x01..0x08 in order, then valid_o=0 and data_o=0.
- Full with simultaneous valid_i=1, ready_i=1, DEPTHFIFO=8, count=8 → one pop, no push, count_o=7. Next cycle a push plus pop keeps count_o=7.
- Wrap, DEPTHFIFO=5, both REGOUT values: stream 0..19 with ready_i toggling each cycle → output sequence 0..19 exactly, and count_o never exceeds 5.
- Flags, ALMOSTFULL=6, ALMOSTEMPTY=2: push 7 entries → almost_empty_o falls when count=3 and almost_full_o rises when count=6. Pop back to 2 → almost_empty_o=1 on that edge.
- Flush with concurrent handshake: count=4, flush_i=1, valid_i=1, ready_i=1 in the same cycle → count_o=0, valid_o=0, ready_o=1 next cycle. A later push of 0xAA is the first value read.
- Asynchronous reset mid-stream: count=3, drop rstn_i between edges → outputs take reset values before the next edge. After release, a push of 0x55 appears on data_o one cycle later.
